regfile: RTL and testbench



---
 rtl/core_pkg.sv | 22 ++
 rtl/regfile.sv | 42 ++++
 tb/tb_regfile.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types and integer register file geometry.
package core_pkg;

    localparam int WIDTH   = 64;
    localparam int NREGS   = 32;
    localparam int ZERO_RG = 31;

    typedef logic [4:0]       reg_addr_t;
    typedef logic [WIDTH-1:0] word_t;

    // Physical storage only: XZR has no backing register.
    typedef logic [NREGS-2:0][WIDTH-1:0] reg_arr_t;

    function automatic reg_arr_t regfile_reset_image();
        reg_arr_t img;
        for (int i = 0; i < NREGS - 1; i++) begin
            img[i] = word_t'(i);
        end
        return img;
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 64-bit integer register file, XZR at index 31.
// Two combinational read ports, one synchronous write port.
module regfile
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t ra1,
    input  reg_addr_t ra2,
    input  reg_addr_t wa3,
    input  word_t     wd3,
    input  logic      we3,
    output word_t     rd1,
    output word_t     rd2
);

    localparam reg_addr_t XZR_ADDR = reg_addr_t'(ZERO_RG);

    // Power-up image matches the reset image so storage is never X.
    reg_arr_t regs_q = regfile_reset_image();

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= regfile_reset_image();
        end else if (we3 && (wa3 != XZR_ADDR)) begin
            regs_q[wa3] <= wd3;
        end
    end

    function automatic word_t regfile_read(input reg_addr_t addr);
        return (addr == XZR_ADDR) ? '0 : regs_q[addr];
    endfunction

    always_comb begin
        rd1 = regfile_read(ra1);
    end

    always_comb begin
        rd2 = regfile_read(ra2);
    end

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for the integer register file.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic        we3;
    logic [63:0] rd1;
    logic [63:0] rd2;

    typedef struct packed {
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m[32];
    int          checks = 0;
    int          errors = 0;

    regfile dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .we3   (we3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mread(input logic [4:0] a);
        return (a == 5'd31) ? 64'd0 : m[a];
    endfunction

    task automatic model_init();
        for (int i = 0; i < 32; i++) begin
            m[i] = (i == 31) ? 64'd0 : 64'(i);
        end
    endtask

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    // Drive read addresses, push expectation, then compare.
    task automatic rd(input logic [4:0] a1,
                      input logic [4:0] a2,
                      input string tag);
        exp_t e;
        ra1 = a1;
        ra2 = a2;
        sb.push_back('{e1: mread(a1), e2: mread(a2)});
        #1;
        e = sb.pop_front();
        check({tag, "/rd1"}, rd1, e.e1);
        check({tag, "/rd2"}, rd2, e.e2);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_init();
        end else if (we3 && wa3 != 5'd31) begin
            m[wa3] = wd3;
        end
        @(negedge clk);
    endtask

    initial begin
        model_init();
        reset = 1'b0;
        we3   = 1'b0;
        wa3   = 5'd0;
        wd3   = 64'd0;
        ra1   = 5'd0;
        ra2   = 5'd0;

        rd(5'd4, 5'd31, "init");

        @(negedge clk);
        reset = 1'b1;
        tick();
        reset = 1'b0;

        for (int k = 0; k < 32; k++) begin
            rd(5'(k), 5'(k), $sformatf("sweep%0d", k));
        end
        @(negedge clk);

        we3 = 1'b0; wa3 = 5'd18; wd3 = 64'd69;
        tick();
        rd(5'd18, 5'd0, "we0");

        we3 = 1'b1; wa3 = 5'd18; wd3 = 64'd9;
        rd(5'd18, 5'd18, "pre_edge");
        tick();
        rd(5'd18, 5'd18, "post_edge");

        we3 = 1'b0; wd3 = 64'd10;
        tick();
        rd(5'd18, 5'd17, "hold");

        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hDEAD_BEEF;
        tick();
        we3 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rd(5'(k), 5'(31 - k), $sformatf("xzr%0d", k));
        end
        @(negedge clk);

        we3 = 1'b1; wa3 = 5'd5; wd3 = '1;
        tick();
        we3 = 1'b0;
        rd(5'd5, 5'd6, "x5_ones");

        reset = 1'b1;
        we3 = 1'b1; wa3 = 5'd5; wd3 = 64'd7;
        tick();
        reset = 1'b0;
        we3 = 1'b0;
        rd(5'd5, 5'd18, "rst_wins");

        ra1 = 5'd3; ra2 = 5'd7;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 64'h0123_4567_89AB_CDEF;
        tick();
        rd(5'd3, 5'd7, "indep_x3");
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hFEDC_BA98_7654_3210;
        tick();
        rd(5'd3, 5'd7, "indep_x7");

        for (int n = 0; n < 40; n++) begin
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom);
            wd3 = {$urandom, $urandom};
            tick();
            rd(5'($urandom), wa3, $sformatf("rand%0d", n));
        end
        we3 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
